uart_decrypt_relay: RTL and testbench

Receiving-end counterpart of the encrypt-and-store relay. It takes ciphertext bytes from a `uart_rx` instance and regenerates the identical LFSR keystream, so each byte is decrypted as it arrives. Plaintext is buffered in on-chip BRAM, and in playback mode the block drives a `uart_tx` instance byte by byte. It sits between the existing `uart_rx` and `uart_tx` modules at the decrypting end of the link.

---
 rtl/crypt_pkg.sv | 21 ++
 rtl/uart_decrypt_relay_if.sv | 26 ++
 rtl/lfsr_keystream.sv | 25 ++
 rtl/uart_decrypt_relay.sv | 123 ++++++++++++
 tb/tb_uart_decrypt_relay.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/crypt_pkg.sv
// Shared keystream definitions for the encrypt/decrypt relay pair.
// Both ends must agree on seed, taps and step order to stay in sync.
package crypt_pkg;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Feedback taps at bits 7, 5, 4 and 3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } play_state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/uart_decrypt_relay_if.sv
// Bundle of the rx-side, control and tx-side signals around the decrypt relay.
// slave = the relay itself, master = whatever sits on the uart_rx/uart_tx side.
interface uart_decrypt_relay_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]      in_data;
  logic            in_valid;
  logic            mode;
  logic            clear;
  logic            tx_busy;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic            play_done;

  modport slave (
    input  in_data, in_valid, mode, clear, tx_busy,
    output tx_start, tx_data, count, overflow, play_done
  );

  modport master (
    output in_data, in_valid, mode, clear, tx_busy,
    input  tx_start, tx_data, count, overflow, play_done
  );
endinterface

// File: rtl/lfsr_keystream.sv
// 8-bit keystream generator; key is the value to use now, advance steps it.
// clear has priority over advance so a clear always lands exactly on the seed.
module lfsr_keystream
  import crypt_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       advance,
  output logic [7:0] key
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key <= SEED;
    end else if (clear) begin
      key <= SEED;
    end else if (advance) begin
      key <= lfsr_next(key);
    end
  end

endmodule

// File: rtl/uart_decrypt_relay.sv
// Decrypts bytes from uart_rx into a BRAM buffer and replays them to uart_tx.
//
// state        | meaning
// ST_IDLE      | waiting; in playback, starts next byte or flags play_done
// ST_READ      | rd_ptr presented to the BRAM
// ST_START     | BRAM data captured into tx_data, tx_start pulsed
// ST_WAIT_BUSY | waiting for uart_tx to go busy
// ST_WAIT_DONE | waiting for uart_tx to finish the frame
module uart_decrypt_relay
  import crypt_pkg::*;
#(
  parameter int         DEPTH  = 4096,
  parameter int         ADDR_W = 12,
  parameter logic [7:0] SEED   = LFSR_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_decrypt_relay_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  logic            in_valid_d;
  logic            accept;
  logic            full;
  logic [7:0]      key;
  logic [ADDR_W:0] count_q;
  logic            overflow_q;
  logic [ADDR_W:0] rd_ptr;
  logic [7:0]      rd_q;
  logic [7:0]      mem [DEPTH];
  play_state_t     state;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic            play_done_q;

  assign accept = bus.in_valid & ~in_valid_d & ~bus.mode;
  assign full   = (count_q == FULL_CNT);

  // The keystream advances even when full so we stay aligned with the sender
  lfsr_keystream #(.SEED(SEED)) u_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.clear),
    .advance (accept & ~bus.clear),
    .key     (key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_d <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      in_valid_d <= bus.in_valid;
      if (bus.clear) begin
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if (accept) begin
        if (full) overflow_q <= 1'b1;
        else      count_q    <= count_q + ONE;
      end
    end
  end

  // Write address is the fill level; the read port is registered every cycle
  always_ff @(posedge clk) begin
    if (accept && !bus.clear && !full) begin
      mem[count_q[ADDR_W-1:0]] <= bus.in_data ^ key;
    end
    rd_q <= mem[rd_ptr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rd_ptr      <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      play_done_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      if (bus.clear) begin
        state       <= ST_IDLE;
        rd_ptr      <= '0;
        play_done_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!bus.mode) begin
              rd_ptr      <= '0;
              play_done_q <= 1'b0;
            end else if (rd_ptr < count_q) begin
              play_done_q <= 1'b0;
              state       <= ST_READ;
            end else begin
              play_done_q <= 1'b1;
            end
          end
          ST_READ: state <= bus.mode ? ST_START : ST_IDLE;
          ST_START: begin
            tx_data_q  <= rd_q;
            tx_start_q <= 1'b1;
            rd_ptr     <= rd_ptr + ONE;
            state      <= ST_WAIT_BUSY;
          end
          // Once started, a byte always runs to completion even if mode drops
          ST_WAIT_BUSY: if (bus.tx_busy)  state <= ST_WAIT_DONE;
          ST_WAIT_DONE: if (!bus.tx_busy) state <= ST_IDLE;
          default:      state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.play_done = play_done_q;

endmodule

// File: tb/tb_uart_decrypt_relay.sv
// Randomized bench for uart_decrypt_relay with a queue-based plaintext model
// and a behavioural uart_tx that records every started byte.
module tb_uart_decrypt_relay;

  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 12;
  localparam int FRAME  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  int overlap   = 0;

  logic [7:0] tx_q[$];
  logic [7:0] m_q[$];
  logic [7:0] m_key;

  uart_decrypt_relay_if #(.ADDR_W(ADDR_W)) bus ();

  uart_decrypt_relay #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .SEED   (8'h01)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Keystream step from its definition: shift left, feed in parity of bits 7,5,4,3
  function automatic logic [7:0] step_key(input logic [7:0] k);
    int ones;
    ones = int'(k[7]) + int'(k[5]) + int'(k[4]) + int'(k[3]);
    return 8'(((int'(k) * 2) % 256) + (ones % 2));
  endfunction

  // uart_tx stand-in: busy for FRAME cycles after each start; flags restarts while busy
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        start_cnt++;
        if (bus.tx_busy) overlap++;
        tx_q.push_back(bus.tx_data);
        bus.tx_busy = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
          @(negedge clk);
          if (bus.tx_start === 1'b1) begin
            start_cnt++;
            overlap++;
            tx_q.push_back(bus.tx_data);
          end
        end
        bus.tx_busy = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    if (!bus.mode) begin
      if (m_q.size() < DEPTH) m_q.push_back(b ^ m_key);
      m_key = step_key(m_key);
    end
    tick();
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    m_q.delete();
    m_key = 8'h01;
    tick();
  endtask

  task automatic wait_play_done(input int budget);
    int i;
    i = 0;
    while (bus.play_done !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
  endtask

  task automatic play_and_check(input string tag);
    int base, errs;
    tx_q.delete();
    base = start_cnt;
    bus.mode = 1'b1;
    wait_play_done((m_q.size() + 2) * (FRAME + 14) + 20);
    chk({tag, "_play_done"}, bus.play_done, 1'b1);
    chk({tag, "_starts"}, start_cnt - base, m_q.size());
    chk({tag, "_count"}, bus.count, m_q.size());
    errs = 0;
    for (int i = 0; i < m_q.size(); i++) begin
      if (i >= tx_q.size()) errs++;
      else if (m_q.size() <= 32) chk($sformatf("%s_byte%0d", tag, i), tx_q[i], m_q[i]);
      else if (tx_q[i] !== m_q[i]) errs++;
    end
    chk({tag, "_missing_or_bad"}, errs, 0);
    bus.mode = 1'b0;
    tick(3);
    chk({tag, "_play_done_drop"}, bus.play_done, 1'b0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, base, i;
    logic [7:0] k, x;

    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.mode     = 1'b0;
    bus.clear    = 1'b0;
    m_key        = 8'h01;

    tick(3);
    chk("rst_tx_start", bus.tx_start, 1'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_count", bus.count, 0);
    chk("rst_overflow", bus.overflow, 1'b0);
    chk("rst_play_done", bus.play_done, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // "Hi"
    send(8'h49);
    send(8'h6B);
    chk("hi_count", bus.count, 2);
    play_and_check("hi");
    chk("hi_H", tx_q[0], 8'h48);
    chk("hi_i", tx_q[1], 8'h69);

    // Round trip against an independent encryptor
    do_clear();
    k = 8'h01;
    for (int j = 0; j < 16; j++) begin
      send(8'(j) ^ k);
      k = step_key(k);
    end
    play_and_check("rt");
    for (int j = 0; j < 16 && j < tx_q.size(); j++)
      chk($sformatf("rt_plain%0d", j), tx_q[j], 8'(j));

    // in_valid held high: one byte only
    do_clear();
    x = 8'($urandom);
    bus.in_data  = x;
    bus.in_valid = 1'b1;
    m_q.push_back(x ^ m_key);
    m_key = step_key(m_key);
    tick(5);
    bus.in_valid = 1'b0;
    tick();
    chk("hold_count", bus.count, 1);
    send(8'($urandom));
    play_and_check("hold");

    // clear wins over a simultaneous accept
    do_clear();
    bus.in_data  = 8'($urandom);
    bus.in_valid = 1'b1;
    bus.clear    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    tick();
    chk("clr_win_count", bus.count, 0);

    // random loads, bytes ignored in playback, then append
    for (int j = 0; j < 10; j++) begin
      send(8'($urandom));
      tick($urandom_range(0, 3));
    end
    play_and_check("rnd1");
    bus.mode = 1'b1;
    wait_play_done(10 * (FRAME + 14) + 20);
    for (int j = 0; j < 3; j++) send(8'($urandom));
    chk("ignored_count", bus.count, 10);
    bus.mode = 1'b0;
    tick(3);
    for (int j = 0; j < 5; j++) send(8'($urandom));
    play_and_check("rnd2");

    // mode drop during byte 2 of 4
    do_clear();
    for (int j = 0; j < 4; j++) send(8'($urandom));
    tx_q.delete();
    base = start_cnt;
    seen = 0;
    i = 0;
    bus.mode = 1'b1;
    while (seen < 2 && i < 200) begin
      tick();
      if (bus.tx_start === 1'b1) seen++;
      i++;
    end
    bus.mode = 1'b0;
    tick(FRAME + 20);
    chk("drop_starts", start_cnt - base, 2);
    if (tx_q.size() >= 2) chk("drop_byte2", tx_q[1], m_q[1]);
    chk("drop_count", bus.count, 4);
    play_and_check("replay");

    // fill, overflow, clear
    do_clear();
    for (int j = 0; j < DEPTH; j++) send(8'($urandom));
    chk("fill_overflow_pre", bus.overflow, 1'b0);
    send(8'($urandom));
    chk("full_count", bus.count, DEPTH);
    chk("full_overflow", bus.overflow, 1'b1);
    play_and_check("full");
    do_clear();
    chk("clr_overflow", bus.overflow, 1'b0);
    send(8'h01);
    play_and_check("post_clr");
    chk("post_clr_plain", tx_q[0], 8'h00);

    // async reset during playback
    do_clear();
    for (int j = 0; j < 3; j++) send(8'($urandom));
    bus.mode = 1'b1;
    i = 0;
    while (bus.tx_start !== 1'b1 && i < 100) begin
      tick();
      i++;
    end
    chk("rstplay_started", bus.tx_start, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstplay_tx_start", bus.tx_start, 1'b0);
    chk("rstplay_count", bus.count, 0);
    chk("rstplay_play_done", bus.play_done, 1'b0);
    bus.mode = 1'b0;
    tick();
    rst_n = 1'b1;
    m_q.delete();
    m_key = 8'h01;
    tick(FRAME + 4);
    send(8'h01);
    play_and_check("after_rst");
    chk("after_rst_plain", tx_q[0], 8'h00);

    chk("no_restart_while_busy", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
